// File: rtl/traffic_phase_fsm.sv
// ---------------------------------------------------------------------------
// traffic_phase_fsm
//   Phase controller for a two-street intersection. It produces the one-hot
//   light codes for both streets and, for each street, the number of seconds
//   until its light changes colour. Those counts drive the countdown display
//   stage downstream. The block contains its own 1 s prescaler, a phase timer,
//   pedestrian shortening of green, and a night flashing-yellow mode.
//
// Ports
//   clk          in   system clock; all logic runs on posedge
//   rst          in   synchronous, active-high reset
//   ped_req      in   request to shorten the currently active green
//   night        in   night-mode request (level)
//   street_a     out  [2:0] street A light: 100 red, 010 yellow, 001 green, 000 dark
//   street_b     out  [2:0] street B light, same encoding
//   count_a      out  [5:0] seconds until street A changes colour (0 at night)
//   count_b      out  [5:0] seconds until street B changes colour (0 at night)
//   sec_tick     out  one-cycle pulse, once per second
//   phase_start  out  one-cycle pulse in the first cycle of each new phase
// ---------------------------------------------------------------------------
module traffic_phase_fsm #(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int GREEN_SEC   = 45,
    parameter int YELLOW_SEC  = 5,
    parameter int ALL_RED_SEC = 2,
    parameter int PED_MIN_SEC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] street_a,
    output logic [2:0] street_b,
    output logic [5:0] count_a,
    output logic [5:0] count_b,
    output logic       sec_tick,
    output logic       phase_start
);

    // The largest count shown is s+G+Y+R during all-red, which is G+Y+2R-1.
    // It must fit in 6 bits.
    if (GREEN_SEC + YELLOW_SEC + 2 * ALL_RED_SEC - 1 > 63) begin : g_width_err
        $error("traffic_phase_fsm: GREEN+YELLOW+2*ALL_RED-1 exceeds 63");
    end
    if (CLK_PER_SEC < 2 || GREEN_SEC < 1 || YELLOW_SEC < 1 || ALL_RED_SEC < 1 ||
        PED_MIN_SEC < 1 || PED_MIN_SEC > GREEN_SEC) begin : g_param_err
        $error("traffic_phase_fsm: illegal timing parameter");
    end

    localparam int PW = $clog2(CLK_PER_SEC);

    localparam logic [PW-1:0] PRESC_LOAD = PW'(CLK_PER_SEC - 1);
    localparam logic [5:0]    G_LOAD     = 6'(GREEN_SEC - 1);
    localparam logic [5:0]    Y_LOAD     = 6'(YELLOW_SEC - 1);
    localparam logic [5:0]    R_LOAD     = 6'(ALL_RED_SEC - 1);
    localparam logic [5:0]    PED_LOAD   = 6'(PED_MIN_SEC - 1);
    localparam logic [5:0]    YR         = 6'(YELLOW_SEC + ALL_RED_SEC);
    localparam logic [5:0]    R6         = 6'(ALL_RED_SEC);
    localparam logic [5:0]    GYR        = 6'(GREEN_SEC + YELLOW_SEC + ALL_RED_SEC);

    localparam logic [2:0] L_RED  = 3'b100;
    localparam logic [2:0] L_YEL  = 3'b010;
    localparam logic [2:0] L_GRN  = 3'b001;
    localparam logic [2:0] L_DARK = 3'b000;

    typedef enum logic [2:0] {
        S_A_GREEN   = 3'd0,
        S_A_YELLOW  = 3'd1,
        S_ALL_RED_1 = 3'd2,
        S_B_GREEN   = 3'd3,
        S_B_YELLOW  = 3'd4,
        S_ALL_RED_2 = 3'd5,
        S_NIGHT     = 3'd6
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [5:0]      r_sec_left, w_sec_left_nxt;
    logic [PW-1:0]   r_presc;
    logic            r_flash, w_flash_nxt;
    logic            r_phase_start, w_phase_start_nxt;
    // r_boot is set only for the ALL_RED_2 phase that follows reset. In that
    // phase count_b shows the bare phase timer. From the next phase on,
    // count_b uses the normal decode.
    logic            r_boot, w_boot_nxt;
    logic            w_tick;
    logic            w_expire;

    assign w_tick   = (r_presc == '0);
    assign w_expire = w_tick && (r_sec_left == '0);

    // NOTE: reset is sampled on the clock edge, so it is a plain branch inside
    // the clocked process and has no entry in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_ALL_RED_2;
            r_sec_left    <= R_LOAD;
            r_presc       <= PRESC_LOAD;
            r_flash       <= 1'b0;
            r_phase_start <= 1'b0;
            r_boot        <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments. Every register here updates from
            // the values present before the edge, whatever order the lines are in.
            r_state       <= w_state_nxt;
            r_sec_left    <= w_sec_left_nxt;
            r_presc       <= w_tick ? PRESC_LOAD : r_presc - 1'b1;
            r_flash       <= w_flash_nxt;
            r_phase_start <= w_phase_start_nxt;
            r_boot        <= w_boot_nxt;
        end
    end

    // Next-state logic and phase timer.
    always_comb begin
        // NOTE: every signal gets a default first. Paths that leave one
        // unassigned would otherwise infer a latch.
        w_state_nxt       = r_state;
        w_sec_left_nxt    = r_sec_left;
        w_flash_nxt       = r_flash;
        w_phase_start_nxt = 1'b0;

        case (r_state)
            S_A_GREEN, S_B_GREEN: begin
                if (w_expire) begin
                    w_state_nxt       = (r_state == S_A_GREEN) ? S_A_YELLOW : S_B_YELLOW;
                    w_sec_left_nxt    = Y_LOAD;
                    w_phase_start_nxt = 1'b1;
                end else if (ped_req && r_sec_left > PED_LOAD) begin
                    // The clamp takes priority over a decrement in the same cycle.
                    w_sec_left_nxt = PED_LOAD;
                end else if (w_tick) begin
                    w_sec_left_nxt = r_sec_left - 6'd1;
                end
            end
            S_A_YELLOW, S_B_YELLOW: begin
                if (w_expire) begin
                    w_state_nxt       = (r_state == S_A_YELLOW) ? S_ALL_RED_1 : S_ALL_RED_2;
                    w_sec_left_nxt    = R_LOAD;
                    w_phase_start_nxt = 1'b1;
                end else if (w_tick) begin
                    w_sec_left_nxt = r_sec_left - 6'd1;
                end
            end
            S_ALL_RED_1, S_ALL_RED_2: begin
                if (w_expire) begin
                    w_phase_start_nxt = 1'b1;
                    if (night) begin
                        w_state_nxt    = S_NIGHT;
                        w_sec_left_nxt = '0;
                        w_flash_nxt    = 1'b0;
                    end else begin
                        w_state_nxt    = (r_state == S_ALL_RED_1) ? S_B_GREEN : S_A_GREEN;
                        w_sec_left_nxt = G_LOAD;
                    end
                end else if (w_tick) begin
                    w_sec_left_nxt = r_sec_left - 6'd1;
                end
            end
            S_NIGHT: begin
                if (w_tick) begin
                    if (!night) begin
                        w_state_nxt       = S_ALL_RED_2;
                        w_sec_left_nxt    = R_LOAD;
                        w_flash_nxt       = 1'b0;
                        w_phase_start_nxt = 1'b1;
                    end else begin
                        w_flash_nxt = ~r_flash;
                    end
                end
            end
            default: begin
                w_state_nxt       = S_ALL_RED_2;
                w_sec_left_nxt    = R_LOAD;
                w_flash_nxt       = 1'b0;
                w_phase_start_nxt = 1'b1;
            end
        endcase

        // The boot phase ends on the first phase change.
        w_boot_nxt = r_boot && !w_phase_start_nxt;
    end

    // Output decode. Every output comes from registers only.
    always_comb begin
        street_a = L_RED;
        street_b = L_RED;
        count_a  = r_sec_left;
        count_b  = r_sec_left;

        case (r_state)
            S_A_GREEN: begin
                street_a = L_GRN;
                count_b  = r_sec_left + YR;
            end
            S_A_YELLOW: begin
                street_a = L_YEL;
                count_b  = r_sec_left + R6;
            end
            S_ALL_RED_1: begin
                count_a = r_sec_left + GYR;
            end
            S_B_GREEN: begin
                street_b = L_GRN;
                count_a  = r_sec_left + YR;
            end
            S_B_YELLOW: begin
                street_b = L_YEL;
                count_a  = r_sec_left + R6;
            end
            S_ALL_RED_2: begin
                count_b = r_boot ? r_sec_left : r_sec_left + GYR;
            end
            S_NIGHT: begin
                street_a = r_flash ? L_YEL : L_DARK;
                street_b = r_flash ? L_YEL : L_DARK;
                count_a  = '0;
                count_b  = '0;
            end
            default: begin
                street_a = L_RED;
                street_b = L_RED;
            end
        endcase
    end

    assign sec_tick    = w_tick;
    assign phase_start = r_phase_start;

endmodule
